// File: rtl/imu_sample_averager_pkg.sv
// Shared types and constants for the IMU sample averager.
package imu_sample_averager_pkg;

   localparam int unsigned IMU_NUM_CH   = 7;
   localparam int unsigned IMU_SAMPLE_W = 16;

   localparam int unsigned IMU_CH_TEMP   = 0;
   localparam int unsigned IMU_CH_ACC_X  = 1;
   localparam int unsigned IMU_CH_ACC_Y  = 2;
   localparam int unsigned IMU_CH_ACC_Z  = 3;
   localparam int unsigned IMU_CH_GYRO_X = 4;
   localparam int unsigned IMU_CH_GYRO_Y = 5;
   localparam int unsigned IMU_CH_GYRO_Z = 6;

   localparam logic [1:0] REG_CONTROL = 2'd0;
   localparam logic [1:0] REG_OVERRUN = 2'd1;
   localparam logic [1:0] REG_SAMPLES = 2'd2;
   localparam logic [1:0] REG_RSVD    = 2'd3;

   typedef logic signed [IMU_SAMPLE_W-1:0] imu_sample_t;
   typedef imu_sample_t [IMU_NUM_CH-1:0]   imu_frame_t;

   typedef enum logic {ST_IDLE, ST_ACCUM} avg_state_e;

   // Requested window exponent limited to the configured maximum.
   function automatic logic [3:0] clamp_log2n(input logic [3:0] req, input int unsigned max_log2);
      return (req > 4'(max_log2)) ? 4'(max_log2) : req;
   endfunction

endpackage

// File: rtl/imu_sample_averager_if.sv
// Frame stream in/out plus Avalon-MM slave for the sample averager.
interface imu_sample_averager_if;
   import imu_sample_averager_pkg::*;

   logic        in_valid;
   imu_frame_t  in_data;
   logic        out_valid;
   logic        out_ready;
   imu_frame_t  out_data;
   logic [1:0]  slave_address;
   logic        slave_read;
   logic [15:0] slave_readdata;
   logic        slave_write;
   logic [15:0] slave_writedata;

   modport slave (
      input  in_valid, in_data, out_ready,
      input  slave_address, slave_read, slave_write, slave_writedata,
      output out_valid, out_data, slave_readdata
   );

   modport master (
      output in_valid, in_data, out_ready,
      output slave_address, slave_read, slave_write, slave_writedata,
      input  out_valid, out_data, slave_readdata
   );
endinterface

// File: rtl/imu_channel_accum.sv
// One channel: sign-extending accumulator with clear and shifted (floor) average.
module imu_channel_accum
   import imu_sample_averager_pkg::*;
#(
   parameter int unsigned ACC_W = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr_i,
   input  logic        add_i,
   input  imu_sample_t sample_i,
   input  logic [3:0]  log2n_i,
   output imu_sample_t avg_c
);

   logic signed [ACC_W-1:0] acc_q, acc_d, sum_c;

   assign sum_c = acc_q + ACC_W'(sample_i);
   // Arithmetic shift floors toward -inf; result always fits the sample width.
   assign avg_c = IMU_SAMPLE_W'(sum_c >>> log2n_i);

   always_comb begin
      acc_d = acc_q;
      if (clr_i)      acc_d = '0;
      else if (add_i) acc_d = sum_c;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/imu_sample_averager.sv
// Averages 2^log2n IMU frames per channel and emits them on a valid/ready stream.
module imu_sample_averager
   import imu_sample_averager_pkg::*;
#(
   parameter int unsigned MAX_LOG2 = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   imu_sample_averager_if.slave   avg_if
);

   localparam int unsigned ACC_W = IMU_SAMPLE_W + MAX_LOG2;
   localparam int unsigned CNT_W = MAX_LOG2 + 1;

   avg_state_e       state_q, state_d;
   logic [3:0]       log2n_q, log2n_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      overrun_q, overrun_d;
   logic             out_valid_q, out_valid_d;
   imu_frame_t       out_data_q, out_data_d;
   logic [15:0]      rdata_q, rdata_d;

   logic             wr_ctrl_c, abort_c, accept_c, complete_c, clear_c;
   logic [3:0]       new_log2n_c;
   logic [CNT_W-1:0] count_inc_c, win_len_c;
   imu_frame_t       avg_c;
   logic             unused_wdata;

   assign wr_ctrl_c   = avg_if.slave_write && (avg_if.slave_address == REG_CONTROL);
   assign new_log2n_c = clamp_log2n(avg_if.slave_writedata[7:4], MAX_LOG2);
   assign count_inc_c = count_q + CNT_W'(1);
   assign win_len_c   = CNT_W'(1) << log2n_q;
   assign unused_wdata = ^{avg_if.slave_writedata[15:8], avg_if.slave_writedata[3:1]};

   for (genvar ch = 0; ch < IMU_NUM_CH; ch++) begin : g_ch
      imu_channel_accum #(.ACC_W(ACC_W)) u_acc (
         .clk      (clk),
         .reset    (reset),
         .clr_i    (clear_c | complete_c),
         .add_i    (accept_c),
         .sample_i (avg_if.in_data[ch]),
         .log2n_i  (log2n_q),
         .avg_c    (avg_c[ch])
      );
   end

   // Next-state: control FSM, window counter, output register, overrun and readback.
   always_comb begin
      state_d     = state_q;
      log2n_d     = log2n_q;
      count_d     = count_q;
      overrun_d   = overrun_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      rdata_d     = rdata_q;
      abort_c     = 1'b0;
      accept_c    = 1'b0;
      complete_c  = 1'b0;
      clear_c     = 1'b0;

      if (wr_ctrl_c) begin
         abort_c = (new_log2n_c != log2n_q) || !avg_if.slave_writedata[0];
         log2n_d = new_log2n_c;
         state_d = avg_if.slave_writedata[0] ? ST_ACCUM : ST_IDLE;
      end

      if (state_q == ST_ACCUM) accept_c = avg_if.in_valid && !abort_c;
      else                     clear_c  = 1'b1;
      if (abort_c) clear_c = 1'b1;

      if (accept_c) begin
         if (count_inc_c == win_len_c) begin
            complete_c = 1'b1;
            count_d    = '0;
         end else begin
            count_d    = count_inc_c;
         end
      end
      if (clear_c) count_d = '0;

      if (out_valid_q && avg_if.out_ready) out_valid_d = 1'b0;
      if (complete_c) begin
         if (!out_valid_q || avg_if.out_ready) begin
            out_valid_d = 1'b1;
            out_data_d  = avg_c;
         end else if (overrun_q != 16'hFFFF) begin
            overrun_d = overrun_q + 16'd1;
         end
      end
      if (avg_if.slave_write && (avg_if.slave_address == REG_OVERRUN)) overrun_d = '0;

      if (avg_if.slave_read) begin
         case (avg_if.slave_address)
            REG_CONTROL: rdata_d = {8'h00, log2n_q, 3'b000, state_q == ST_ACCUM};
            REG_OVERRUN: rdata_d = overrun_q;
            REG_SAMPLES: rdata_d = 16'(count_q);
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         log2n_q     <= '0;
         count_q     <= '0;
         overrun_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         log2n_q     <= log2n_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         rdata_q     <= rdata_d;
      end
   end

   assign avg_if.out_valid      = out_valid_q;
   assign avg_if.out_data       = out_data_q;
   assign avg_if.slave_readdata = rdata_q;

endmodule

// File: tb/tb_imu_sample_averager.sv
// Self-checking bench: directed window vectors, corner sequences, randomized run vs. model.
module tb_imu_sample_averager;
   import imu_sample_averager_pkg::*;

   localparam int unsigned MAX_LOG2 = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   imu_sample_averager_if bus ();

   imu_sample_averager #(.MAX_LOG2(MAX_LOG2)) dut (
      .clk    (clk),
      .reset  (reset),
      .avg_if (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int log2n;
      int ch;
      int n;
      int smp [16];
      int exp;
   } vec_t;

   vec_t vecs [8];

   // Reference model state
   int         m_en, m_log2n, m_ovr, m_valid;
   imu_frame_t m_data;
   imu_frame_t win_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.slave_address = a; bus.slave_writedata = d; bus.slave_write = 1'b1;
      @(negedge clk);
      bus.slave_write = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.slave_address = a; bus.slave_read = 1'b1;
      @(negedge clk);
      bus.slave_read = 1'b0;
      d = bus.slave_readdata;
   endtask

   task automatic send(input imu_frame_t f);
      @(negedge clk);
      bus.in_data = f; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      @(negedge clk); bus.out_ready = 1'b1;
      @(negedge clk); bus.out_ready = 1'b0;
   endtask

   function automatic imu_frame_t one_ch(input int ch, input int v);
      imu_frame_t f = '0;
      f[ch] = 16'(v);
      return f;
   endfunction

   function automatic imu_frame_t rand_frame();
      imu_frame_t f;
      for (int c = 0; c < IMU_NUM_CH; c++) f[c] = 16'($urandom);
      return f;
   endfunction

   function automatic int floordiv(input longint s, input longint n);
      longint q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      return int'(q);
   endfunction

   // Model: mean of queued frames with floor rounding.
   function automatic imu_frame_t window_avg();
      imu_frame_t r;
      for (int c = 0; c < IMU_NUM_CH; c++) begin
         longint s = 0;
         foreach (win_q[k]) s += longint'($signed(win_q[k][c]));
         r[c] = 16'(floordiv(s, longint'(win_q.size())));
      end
      return r;
   endfunction

   task automatic model_step(input logic wr_c, input logic wr_o, input logic [15:0] wd,
                             input logic iv, input imu_frame_t ind, input logic ordy);
      int  nl;
      int  acc = 0;
      int  abort = 0;
      int  complete = 0;
      imu_frame_t avg;
      if (wr_c) begin
         nl    = (int'(wd[7:4]) > MAX_LOG2) ? MAX_LOG2 : int'(wd[7:4]);
         abort = (nl != m_log2n) || !wd[0];
      end
      acc = m_en && iv && !abort;
      if (wr_c) begin
         if (abort) win_q.delete();
         m_log2n = nl;
         m_en    = wd[0];
      end
      if (acc) begin
         win_q.push_back(ind);
         if (win_q.size() == (1 << m_log2n)) begin
            avg = window_avg();
            win_q.delete();
            complete = 1;
         end
      end
      if (complete) begin
         if (!m_valid || ordy) begin
            m_valid = 1; m_data = avg;
         end else if (m_ovr != 65535) m_ovr++;
      end else if (m_valid && ordy) m_valid = 0;
      if (wr_o) m_ovr = 0;
   endtask

   initial begin
      logic [15:0] d;
      imu_frame_t  f, prev;

      vecs[0] = '{log2n:2, ch:0, n:4,  smp:'{1,2,3,5,0,0,0,0,0,0,0,0,0,0,0,0}, exp:2};
      vecs[1] = '{log2n:1, ch:6, n:2,  smp:'{-3,-2,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, exp:-3};
      vecs[2] = '{log2n:2, ch:3, n:4,  smp:'{32767,32767,32767,32767,0,0,0,0,0,0,0,0,0,0,0,0}, exp:32767};
      vecs[3] = '{log2n:3, ch:1, n:8,  smp:'{-32768,-32768,-32768,-32768,-32768,-32768,-32768,-32768,0,0,0,0,0,0,0,0}, exp:-32768};
      vecs[4] = '{log2n:4, ch:2, n:16, smp:'{1,2,3,4,5,6,7,8,9,10,11,12,13,14,15,16}, exp:8};
      vecs[5] = '{log2n:0, ch:5, n:1,  smp:'{-7,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, exp:-7};
      vecs[6] = '{log2n:1, ch:4, n:2,  smp:'{-1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, exp:-1};
      vecs[7] = '{log2n:1, ch:2, n:2,  smp:'{32767,-32768,0,0,0,0,0,0,0,0,0,0,0,0,0,0}, exp:-1};

      bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
      bus.slave_address = 0; bus.slave_read = 0; bus.slave_write = 0; bus.slave_writedata = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("reset out_valid", 32'(bus.out_valid), 0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), d);
         check($sformatf("reset reg%0d", a), 32'(d), 0);
      end

      // Directed window vectors
      foreach (vecs[i]) begin
         wr(REG_CONTROL, 16'((vecs[i].log2n << 4) | 1));
         for (int k = 0; k < vecs[i].n; k++) begin
            if (k == vecs[i].n - 1)
               check($sformatf("vec%0d valid before last", i), 32'(bus.out_valid), 0);
            send(one_ch(vecs[i].ch, vecs[i].smp[k]));
         end
         check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 1);
         check($sformatf("vec%0d data", i), 32'(bus.out_data[vecs[i].ch]), 32'(16'(vecs[i].exp)));
         check($sformatf("vec%0d other ch", i), 32'(bus.out_data[(vecs[i].ch + 1) % 7]), 0);
         drain();
         check($sformatf("vec%0d drained", i), 32'(bus.out_valid), 0);
      end

      // log2n clamp
      wr(REG_CONTROL, 16'h00F1);
      rd(REG_CONTROL, d);
      check("clamp control", 32'(d), 32'h0041);

      // Overrun with stalled consumer at log2n=0, then clear
      wr(REG_CONTROL, 16'h0001);
      send(one_ch(0, 10)); send(one_ch(0, 20)); send(one_ch(0, 30));
      check("ovr held data", 32'(bus.out_data[0]), 32'd10);
      rd(REG_OVERRUN, d);
      check("ovr count", 32'(d), 2);
      wr(REG_OVERRUN, 16'h0000);
      rd(REG_OVERRUN, d);
      check("ovr cleared", 32'(d), 0);
      drain();

      // Window abort on log2n change
      wr(REG_CONTROL, 16'h0021);
      send(one_ch(1, 1000)); send(one_ch(1, 1000));
      rd(REG_SAMPLES, d);
      check("samples before abort", 32'(d), 2);
      wr(REG_CONTROL, 16'h0031);
      rd(REG_SAMPLES, d);
      check("samples after abort", 32'(d), 0);
      for (int k = 0; k < 7; k++) send(one_ch(1, k));
      check("abort no early out", 32'(bus.out_valid), 0);
      send(one_ch(1, 7));
      check("abort out_valid", 32'(bus.out_valid), 1);
      check("abort data", 32'(bus.out_data[1]), 32'd3);
      drain();

      // Identical CONTROL write keeps the window
      send(one_ch(1, 4));
      wr(REG_CONTROL, 16'h0031);
      rd(REG_SAMPLES, d);
      check("same write keeps", 32'(d), 1);

      // Full rate pass-through with consumer always ready
      wr(REG_CONTROL, 16'h0001);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         f = rand_frame();
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("rate valid %0d", i), 32'(bus.out_valid), 1);
            check($sformatf("rate data %0d", i), 32'(bus.out_data[i % 7]), 32'(prev[i % 7]));
         end
         bus.in_data = f; bus.in_valid = 1'b1; prev = f;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("rate last data", 32'(bus.out_data[6]), 32'(prev[6]));
      bus.out_ready = 1'b0;
      rd(REG_OVERRUN, d);
      check("rate no overrun", 32'(d), 0);

      // Reset mid-window
      wr(REG_CONTROL, 16'h0021);
      send(one_ch(0, 1)); send(one_ch(0, 1)); send(one_ch(0, 1));
      rd(REG_SAMPLES, d);
      check("count before reset", 32'(d), 3);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      rd(REG_SAMPLES, d);
      check("samples after reset", 32'(d), 0);
      check("valid after reset", 32'(bus.out_valid), 0);

      // Reset with a held frame drops it without counting overrun
      wr(REG_CONTROL, 16'h0001);
      send(one_ch(2, 5));
      check("held before reset", 32'(bus.out_valid), 1);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check("held dropped", 32'(bus.out_valid), 0);
      rd(REG_OVERRUN, d);
      check("held no overrun", 32'(d), 0);

      // Randomized run against the reference model
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      m_en = 0; m_log2n = 0; m_ovr = 0; m_valid = 0; m_data = '0; win_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic wr_c, wr_o, iv, ordy;
         logic [15:0] wd;
         imu_frame_t ind;
         wr_c = ($urandom_range(0, 39) == 0);
         wr_o = !wr_c && ($urandom_range(0, 99) == 0);
         wd   = {8'h00, 4'($urandom_range(0, 6)), 3'b000, 1'($urandom_range(0, 7) != 0)};
         iv   = !wr_o && ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 2) != 0);
         ind  = rand_frame();
         bus.slave_write     = wr_c | wr_o;
         bus.slave_address   = wr_o ? REG_OVERRUN : REG_CONTROL;
         bus.slave_writedata = wd;
         bus.in_valid        = iv;
         bus.in_data         = ind;
         bus.out_ready       = ordy;
         model_step(wr_c, wr_o, wd, iv, ind, ordy);
         @(negedge clk);
         bus.slave_write = 1'b0;
         bus.in_valid    = 1'b0;
         if (bus.out_valid !== 1'(m_valid)) begin
            check($sformatf("rand valid cyc%0d", cyc), 32'(bus.out_valid), 32'(m_valid));
         end else if (m_valid) begin
            for (int c = 0; c < IMU_NUM_CH; c++)
               check($sformatf("rand data cyc%0d ch%0d", cyc, c), 32'(bus.out_data[c]), 32'(m_data[c]));
         end else begin
            check($sformatf("rand valid cyc%0d", cyc), 32'(bus.out_valid), 0);
         end
      end
      bus.out_ready = 1'b0;
      rd(REG_OVERRUN, d);
      check("rand overrun", 32'(d), 32'(m_ovr));
      rd(REG_SAMPLES, d);
      check("rand samples", 32'(d), 32'(win_q.size()));
      rd(REG_CONTROL, d);
      check("rand control", 32'(d), 32'((m_log2n << 4) | m_en));
      rd(REG_RSVD, d);
      check("reserved reg", 32'(d), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
